// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM state codes,
// write-back source selects, ALU function names and the decoded-instruction record.
package cpu_pkg;

  // ALU instructions are any word with ir[15] = 0; the rest use a full nibble.
  localparam logic       OP_ALU_MSB = 1'b0;
  localparam logic [3:0] OP_MVI     = 4'b1000;
  localparam logic [3:0] OP_LD      = 4'b1001;
  localparam logic [3:0] OP_ST      = 4'b1010;
  localparam logic [3:0] OP_HLT     = 4'b1111;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_IMM = 2'b01;
  localparam logic [1:0] WSEL_MEM = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASS
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_MVI, CLS_LD, CLS_ST, CLS_HLT, CLS_ILL
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    logic [2:0] waddr;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] imm;
    alu_op_e    alu_op;
  } dec_t;

  // Register-file write source for an instruction that reaches write-back.
  function automatic logic [1:0] wsel_for(input instr_cls_e cls);
    case (cls)
      CLS_MVI: return WSEL_IMM;
      CLS_LD:  return WSEL_MEM;
      default: return WSEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// extracts register selects, immediate and ALU function.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  always_comb begin
    dec         = '0;
    dec.waddr   = ir[11:9];
    dec.raddr_a = ir[8:6];
    dec.raddr_b = ir[5:3];
    dec.imm     = ir[7:0];
    dec.alu_op  = alu_op_e'(ir[14:12]);
    if (ir[15] == OP_ALU_MSB) begin
      dec.cls = CLS_ALU;
    end else begin
      case (ir[15:12])
        OP_MVI: dec.cls = CLS_MVI;
        OP_LD:  dec.cls = CLS_LD;
        OP_ST: begin
          // A store reads the register named in the destination field.
          dec.cls     = CLS_ST;
          dec.raddr_a = ir[11:9];
        end
        OP_HLT:  dec.cls = CLS_HLT;
        default: dec.cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, decodes them and
// drives register-file, ALU-flag and data-memory strobes one state at a time.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  input  logic            dmem_ack,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [1:0]      rf_wsel,
  output logic [2:0]      alu_op,
  output logic            flag_we,
  output logic [7:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      dbg_state
);

  // Handshake: a request stays high with address/we stable until the cycle in
  // which its ack is sampled high; acks seen in any other state are ignored.
  logic [2:0]  state, state_nxt;
  logic [15:0] ir;
  dec_t        dec;

  cpu_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          CLS_ALU:         state_nxt = S_EXEC;
          CLS_MVI:         state_nxt = S_WB;
          CLS_LD, CLS_ST:  state_nxt = S_MEM;
          default:         state_nxt = S_HALT;
        endcase
      end
      S_EXEC:   state_nxt = S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          if (dec.cls == CLS_LD) state_nxt = S_WB;
          else                   state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (state == S_DECODE && dec.cls == CLS_ILL) illegal <= 1'b1;
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    rf_we      = 1'b0;
    rf_wsel    = WSEL_ALU;
    flag_we    = 1'b0;
    rf_waddr   = dec.waddr;
    rf_raddr_a = dec.raddr_a;
    rf_raddr_b = dec.raddr_b;
    imm        = dec.imm;
    alu_op     = dec.alu_op;
    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
      end
      S_EXEC: flag_we = 1'b1;
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (dec.cls == CLS_ST);
        dmem_addr = dec.imm;
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wsel = wsel_for(dec.cls);
      end
      default: ;
    endcase
  end

  assign halted    = (state == S_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: random-latency memory responders, an event monitor
// and an instruction-level reference model feeding an expected-event queue.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int W = 24;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [7:0]  imem_addr, dmem_addr, imm, pc;
  logic [15:0] imem_rdata;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_op, dbg_state;
  logic [1:0]  rf_wsel;
  logic        rf_we, flag_we, halted, illegal;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wsel(rf_wsel), .alu_op(alu_op), .flag_we(flag_we), .imm(imm),
    .pc(pc), .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
  );

  logic [15:0]  mem [256];
  logic [W-1:0] exp_q[$];
  int           exp_lat_q[$];
  int           n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ev_fetch(input logic [7:0] a);
    return {4'd1, 12'd0, a};
  endfunction
  function automatic logic [W-1:0] ev_flag(input logic [2:0] op, input logic [2:0] ra,
                                           input logic [2:0] rb, input logic [7:0] im);
    return {4'd2, 3'd0, op, ra, rb, im};
  endfunction
  function automatic logic [W-1:0] ev_dmem(input logic we, input logic [2:0] ra, input logic [7:0] a);
    return {4'd3, 8'd0, we, ra, a};
  endfunction
  function automatic logic [W-1:0] ev_rf(input logic [1:0] ws, input logic [2:0] wa,
                                         input logic [7:0] im, input logic [5:0] rarb);
    return {4'd4, 1'b0, ws, wa, im, rarb};
  endfunction

  // Reference model: walks the program in memory at instruction granularity.
  task automatic model_exec(input logic [7:0] start, input int max_instr,
                            output logic [7:0] pc_end, output bit halt, output bit ill);
    logic [7:0]  p;
    logic [15:0] ins;
    int          lat;
    p = start; halt = 0; ill = 0;
    for (int k = 0; k < max_instr && !halt; k++) begin
      ins = mem[p];
      exp_q.push_back(ev_fetch(p));
      p = p + 8'd1;
      lat = 0;
      case (ins[15:12])
        4'h8: begin exp_q.push_back(ev_rf(2'b01, ins[11:9], ins[7:0], 6'd0)); lat = 3; end
        4'h9: begin
          exp_q.push_back(ev_dmem(1'b0, 3'd0, ins[7:0]));
          exp_q.push_back(ev_rf(2'b10, ins[11:9], ins[7:0], 6'd0));
          lat = 4;
        end
        4'hA: begin exp_q.push_back(ev_dmem(1'b1, ins[11:9], ins[7:0])); lat = 3; end
        4'hF: halt = 1;
        4'hB, 4'hC, 4'hD, 4'hE: begin halt = 1; ill = 1; end
        default: begin
          exp_q.push_back(ev_flag(ins[14:12], ins[8:6], ins[5:3], ins[7:0]));
          exp_q.push_back(ev_rf(2'b00, ins[11:9], ins[7:0], {ins[8:6], ins[5:3]}));
          lat = 4;
        end
      endcase
      if (!halt && k < max_instr - 1) exp_lat_q.push_back(lat);
    end
    pc_end = p;
  endtask

  // Memory responders: ack after a chosen number of wait cycles, plus optional stray acks.
  int i_fix = 0, i_max = 0, d_fix = 0, d_max = 0;
  int i_left = 0, d_left = 0, i_dly_last = 0, d_dly_last = 0;
  bit i_busy = 0, d_busy = 0, noise = 0;

  always @(negedge clk) begin
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (reset) begin
      i_busy = 0; d_busy = 0;
    end else begin
      if (imem_req) begin
        if (!i_busy) begin
          i_busy = 1; i_left = (i_fix >= 0) ? i_fix : $urandom_range(i_max, 0); i_dly_last = i_left;
        end
        if (i_left == 0) begin imem_ack = 1'b1; imem_rdata = mem[imem_addr]; i_busy = 0; end
        else i_left--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        imem_ack = 1'b1; imem_rdata = 16'($urandom);
      end
      if (dmem_req) begin
        if (!d_busy) begin
          d_busy = 1; d_left = (d_fix >= 0) ? d_fix : $urandom_range(d_max, 0); d_dly_last = d_left;
        end
        if (d_left == 0) begin dmem_ack = 1'b1; d_busy = 0; end
        else d_left--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        dmem_ack = 1'b1;
      end
    end
  end

  // Monitor: turns strobe rising edges into events for the scoreboard.
  bit         p_imem = 0, p_dmem = 0, p_rf = 0, p_flag = 0, lat_on = 0;
  int         imem_len = 0, dmem_len = 0, rf_len = 0, flag_len = 0;
  int         cyc = 0, last_fetch = -1, strobe_cnt = 0;
  logic [7:0] held_iaddr, held_daddr;
  logic       held_we;

  task automatic sb_observe(input logic [W-1:0] ev);
    if (exp_q.size() == 0) check_eq("sb_unexpected", ev, 0);
    else check_eq("sb_event", ev, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      p_imem = 0; p_dmem = 0; p_rf = 0; p_flag = 0;
    end else begin
      if (int'(imem_req) + int'(dmem_req) + int'(rf_we) > 1) check_eq("req_mutex", 1, 0);
      if (imem_req || dmem_req || rf_we || flag_we || dmem_we) strobe_cnt++;
      if (!imem_req && p_imem) check_eq("imem_req_len", imem_len, i_dly_last + 1);
      if (!dmem_req && p_dmem) check_eq("dmem_req_len", dmem_len, d_dly_last + 1);
      if (!rf_we && p_rf) check_eq("rf_we_len", rf_len, 1);
      if (!flag_we && p_flag) check_eq("flag_we_len", flag_len, 1);
      if (imem_req && p_imem) check_eq("imem_addr_stable", imem_addr, held_iaddr);
      if (dmem_req && p_dmem) check_eq("dmem_stable", {dmem_we, dmem_addr}, {held_we, held_daddr});
      if (imem_req && !p_imem) begin
        sb_observe(ev_fetch(imem_addr));
        held_iaddr = imem_addr; imem_len = 0;
        if (lat_on && last_fetch >= 0 && exp_lat_q.size() > 0)
          check_eq("fetch_latency", cyc - last_fetch, exp_lat_q.pop_front());
        last_fetch = cyc;
      end
      if (dmem_req && !p_dmem) begin
        sb_observe(ev_dmem(dmem_we, dmem_we ? rf_raddr_a : 3'd0, dmem_addr));
        held_daddr = dmem_addr; held_we = dmem_we; dmem_len = 0;
      end
      if (rf_we && !p_rf) begin
        sb_observe(ev_rf(rf_wsel, rf_waddr, imm, (rf_wsel == 2'b00) ? {rf_raddr_a, rf_raddr_b} : 6'd0));
        rf_len = 0;
      end
      if (flag_we && !p_flag) begin
        sb_observe(ev_flag(alu_op, rf_raddr_a, rf_raddr_b, imm));
        flag_len = 0;
      end
      if (imem_req) imem_len++;
      if (dmem_req) dmem_len++;
      if (rf_we) rf_len++;
      if (flag_we) flag_len++;
      p_imem = imem_req; p_dmem = dmem_req; p_rf = rf_we; p_flag = flag_we;
    end
  end

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic setup(input int ifx, input int imx, input int dfx, input int dmx,
                       input bit nz, input bit lat);
    do_reset();
    exp_q.delete(); exp_lat_q.delete();
    i_fix = ifx; i_max = imx; d_fix = dfx; d_max = dmx; noise = nz; lat_on = lat;
    last_fetch = -1;
    for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    check_eq("halt_reached", halted, 1'b1);
  endtask

  task automatic finish_prog(input string tag, input logic [7:0] pc_exp, input bit ill_exp);
    repeat (2) @(negedge clk);
    check_eq({tag, "_halted"}, halted, 1'b1);
    check_eq({tag, "_illegal"}, illegal, ill_exp);
    check_eq({tag, "_pc"}, pc, pc_exp);
    check_eq({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v = 16'($urandom);
    case ($urandom_range(3, 0))
      0: v[15] = 1'b0;
      1: v[15:12] = 4'h8;
      2: v[15:12] = 4'h9;
      default: v[15:12] = 4'hA;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pc_exp;
    bit         h, ill;
    int         n, base;

    // Reset values and IDLE with run low
    setup(0, 0, 0, 0, 0, 0);
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_status", {halted, illegal}, 2'b00);
    check_eq("rst_strobes", {imem_req, dmem_req, dmem_we, rf_we, flag_we}, 5'b0);
    base = strobe_cnt;
    repeat (5) @(negedge clk);
    check_eq("idle_no_strobes", strobe_cnt - base, 0);

    // Directed program with zero-wait memory
    setup(0, 0, 0, 0, 0, 1);
    mem[0] = 16'h8007; mem[1] = 16'h8202; mem[2] = 16'h0E08; mem[3] = 16'hAEFF; mem[4] = 16'hF000;
    model_exec(8'h00, 50, pc_exp, h, ill);
    run = 1'b1;
    wait_halt(200);
    finish_prog("prog5", pc_exp, ill);
    check_eq("prog5_pc_is_5", pc, 8'h05);
    check_eq("prog5_lat_used", exp_lat_q.size(), 0);

    // Delayed instruction fetch
    setup(3, 0, 0, 0, 0, 0);
    mem[0] = 16'h8007;
    model_exec(8'h00, 50, pc_exp, h, ill);
    run = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    while (imem_req && n < 20) begin @(negedge clk); n++; end
    check_eq("slow_fetch_pc_once", pc, 8'h01);
    wait_halt(100);
    finish_prog("slow_fetch", pc_exp, ill);

    // Load with delayed data ack
    setup(0, 0, 2, 0, 0, 0);
    mem[0] = 16'h9305;
    model_exec(8'h00, 50, pc_exp, h, ill);
    run = 1'b1;
    wait_halt(100);
    finish_prog("ld_slow", pc_exp, ill);

    // run dropped during EXEC, then resumed
    setup(0, 0, 0, 0, 0, 0);
    mem[0] = 16'h0E08; mem[1] = 16'h8001;
    model_exec(8'h00, 1, pc_exp, h, ill);
    run = 1'b1;
    n = 0;
    while (!flag_we && n < 20) begin @(negedge clk); n++; end
    check_eq("exec_seen", flag_we, 1'b1);
    run = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("stop_state_idle", dbg_state, S_IDLE);
    check_eq("stop_pc_kept", pc, pc_exp);
    check_eq("stop_sb_drained", exp_q.size(), 0);
    model_exec(pc_exp, 50, pc_exp, h, ill);
    run = 1'b1;
    wait_halt(100);
    finish_prog("resume", pc_exp, ill);

    // Illegal opcode halts and ignores everything afterwards
    setup(0, 0, 0, 0, 0, 0);
    mem[0] = 16'hB000;
    model_exec(8'h00, 50, pc_exp, h, ill);
    run = 1'b1;
    wait_halt(100);
    finish_prog("illegal", pc_exp, ill);
    noise = 1; base = strobe_cnt;
    for (int k = 0; k < 30; k++) begin
      run = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    check_eq("halt_no_strobes", strobe_cnt - base, 0);
    check_eq("halt_sticky", {halted, illegal, pc}, {2'b11, 8'h01});

    // Asynchronous reset in the middle of a data-memory wait
    setup(0, 0, 10, 0, 0, 0);
    mem[0] = 16'h9305;
    model_exec(8'h00, 50, pc_exp, h, ill);
    run = 1'b1;
    n = 0;
    while (!dmem_req && n < 20) begin @(negedge clk); n++; end
    check_eq("mem_wait_seen", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_strobes", {imem_req, dmem_req, dmem_we, rf_we, flag_we}, 5'b0);
    check_eq("arst_addrs", {imem_addr, dmem_addr}, 16'h0000);
    check_eq("arst_status", {pc, halted, illegal, dbg_state}, {8'h00, 2'b00, S_IDLE});

    // PC wrap FF -> 00 over a full pass of random non-halting code
    setup(-1, 1, -1, 1, 1, 0);
    for (int a = 0; a < 256; a++) mem[a] = rand_op();
    model_exec(8'h00, 256, pc_exp, h, ill);
    run = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 8'hFF) && n < 4000) begin @(negedge clk); n++; end
    check_eq("reached_ff", imem_addr, 8'hFF);
    run = 1'b0;
    repeat (14) @(negedge clk);
    check_eq("wrap_pc", pc, 8'h00);
    check_eq("wrap_idle", dbg_state, S_IDLE);
    check_eq("wrap_sb_drained", exp_q.size(), 0);
    mem[0] = 16'hF000;
    model_exec(8'h00, 4, pc_exp, h, ill);
    run = 1'b1;
    wait_halt(100);
    finish_prog("after_wrap", pc_exp, ill);

    // Random programs ending in a halt or an illegal opcode
    for (int t = 0; t < 8; t++) begin
      if (t == 0) setup(0, 0, 0, 0, 0, 1);
      else setup(-1, 3, -1, 3, 1'($urandom_range(1, 0)), 0);
      n = $urandom_range(24, 3);
      for (int a = 0; a < n - 1; a++) mem[a] = rand_op();
      mem[n-1] = {4'($urandom_range(15, 11)), 12'($urandom)};
      model_exec(8'h00, 50, pc_exp, h, ill);
      run = 1'b1;
      wait_halt(2000);
      finish_prog("rand", pc_exp, ill);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
